// File: rtl/uart_status_tx_if.sv
// Status inputs and serial outputs of the game-status UART transmitter.
// master = status source (game controller / key decoder); slave = transmitter.
interface uart_status_tx_if;
  logic       game_start;
  logic       game_over;
  logic       p1_win;
  logic       p1_ready;
  logic       p2_ready;
  logic [3:0] p1_hp;
  logic [3:0] p2_hp;
  logic       send_req;
  logic       tx;
  logic       busy;

  modport master (
    output game_start, game_over, p1_win, p1_ready, p2_ready,
    output p1_hp, p2_hp, send_req,
    input  tx, busy
  );

  modport slave (
    input  game_start, game_over, p1_win, p1_ready, p2_ready,
    input  p1_hp, p2_hp, send_req,
    output tx, busy
  );
endinterface

// File: rtl/uart_status_tx.sv
// 8N1 transmitter sending a 4-byte status frame {A5, S, A, A5^S^A} whenever
// the game status changes or a frame is requested.
module uart_status_tx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic            clk,
  input  logic            rstn,
  uart_status_tx_if.slave bus
);

  localparam int unsigned   DIV       = CLK_FREQ / BAUD;
  localparam int unsigned   CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [7:0]    SYNC      = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   frame_q, frame_d;
  logic [15:0]   last_q, last_d;
  logic          pending_q, pending_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [7:0]    status;
  logic [7:0]    aux;
  logic [15:0]   snap;
  logic          trigger;
  logic          bit_end;
  logic [7:0]    byte_sel;

  assign status  = {3'b000, bus.p2_ready, bus.p1_ready, bus.p1_win,
                    bus.game_over, bus.game_start};
  assign aux     = {bus.p1_hp, bus.p2_hp};
  assign snap    = {status, aux};
  assign trigger = (snap != last_q) || bus.send_req;
  assign bit_end = (baud_q == BAUD_LAST);

  // Sequencing: every state other than IDLE lasts whole bit periods.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    frame_d   = frame_q;
    last_d    = last_q;
    pending_d = pending_q;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (trigger || pending_q) begin
          state_d   = START;
          bit_d     = '0;
          byte_d    = '0;
          frame_d   = {SYNC ^ status ^ aux, aux, status, SYNC};
          last_d    = snap;
          pending_d = 1'b0;
        end
      end

      START: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end

      DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (byte_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            byte_d  = byte_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Any trigger seen mid-frame collapses into a single follow-up frame.
    if (state_q != IDLE && trigger) begin
      pending_d = 1'b1;
    end
  end

  // tx and busy are registered from the next state so the line moves on
  // the same edge the FSM does.
  always_comb begin
    unique case (byte_d)
      2'd0:    byte_sel = frame_d[7:0];
      2'd1:    byte_sel = frame_d[15:8];
      2'd2:    byte_sel = frame_d[23:16];
      default: byte_sel = frame_d[31:24];
    endcase

    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_sel[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      frame_q   <= '0;
      last_q    <= '0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;

endmodule
